// File: rtl/my_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : my_alu_seq
//  Purpose  : Hack-style ALU with registered result/flags and an iterative
//             shift-and-add multiplier behind a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module my_alu_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             zx,
   input  logic             nx,
   input  logic             zy,
   input  logic             ny,
   input  logic             f,
   input  logic             no,
   input  logic             mul,
   output logic [WIDTH-1:0] out,
   output logic             zr,
   output logic             ng,
   output logic             cy,
   output logic             ov,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic [2*WIDTH-1:0] r_mcand;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_mplier;
   logic [CW-1:0]      r_count;

   logic [WIDTH-1:0]   w_xp;
   logic [WIDTH-1:0]   w_yp;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH-1:0]   w_res;
   logic               w_cy;
   logic               w_ov;
   logic [2*WIDTH-1:0] w_acc_next;

   // Operand preprocessing and single-cycle ALU result, evaluated on live inputs
   always_comb begin
      w_xp  = zx ? '0 : x;
      w_xp  = nx ? ~w_xp : w_xp;
      w_yp  = zy ? '0 : y;
      w_yp  = ny ? ~w_yp : w_yp;
      w_sum = {1'b0, w_xp} + {1'b0, w_yp};
      w_res = f ? w_sum[WIDTH-1:0] : (w_xp & w_yp);
      w_res = no ? ~w_res : w_res;
      w_cy  = f & w_sum[WIDTH];
      w_ov  = f & (w_xp[WIDTH-1] == w_yp[WIDTH-1]) & (w_sum[WIDTH-1] != w_xp[WIDTH-1]);
   end

   always_comb begin
      w_acc_next = r_acc;
      if (r_mplier[0]) begin
         w_acc_next = r_acc + r_mcand;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out       <= '0;
         zr        <= 1'b0;
         ng        <= 1'b0;
         cy        <= 1'b0;
         ov        <= 1'b0;
         r_mcand   <= '0;
         r_acc     <= '0;
         r_mplier  <= '0;
         r_count   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  if (mul) begin
                     r_mcand  <= {{WIDTH{1'b0}}, w_xp};
                     r_mplier <= w_yp;
                     r_acc    <= '0;
                     r_count  <= '0;
                     r_state  <= MUL;
                  end else begin
                     out       <= w_res;
                     zr        <= (w_res == '0);
                     ng        <= w_res[WIDTH-1];
                     cy        <= w_cy;
                     ov        <= w_ov;
                     out_valid <= 1'b1;
                     r_state   <= DONE;
                  end
               end
            end
            MUL: begin
               r_acc    <= w_acc_next;
               r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
               r_mplier <= r_mplier >> 1;
               r_count  <= r_count + 1'b1;
               // The last multiplier bit is folded in on the same edge that publishes the product
               if (r_count == C_LAST) begin
                  out       <= w_acc_next[WIDTH-1:0];
                  zr        <= (w_acc_next[WIDTH-1:0] == '0);
                  ng        <= w_acc_next[WIDTH-1];
                  cy        <= |w_acc_next[2*WIDTH-1:WIDTH];
                  ov        <= 1'b0;
                  out_valid <= 1'b1;
                  r_state   <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  r_state   <= IDLE;
               end
            end
            default: begin
               r_state   <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_my_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_my_alu_seq
//  Purpose  : Self-checking bench for my_alu_seq against an arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_my_alu_seq;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] x = '0;
   logic [W-1:0] y = '0;
   logic         zx = 1'b0, nx = 1'b0, zy = 1'b0, ny = 1'b0, f = 1'b0, no = 1'b0, mul = 1'b0;
   logic [W-1:0] out;
   logic         zr, ng, cy, ov, out_valid;
   logic         out_ready = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   my_alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no), .mul(mul),
      .out(out), .zr(zr), .ng(ng), .cy(cy), .ov(ov),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: plain integer arithmetic on the preprocessed operands
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [6:0] c,
                        output logic [W-1:0] eo, output logic ezr, output logic eng,
                        output logic ecy, output logic eov, output int elat);
      longint unsigned ua, ub, mask, r;
      longint sa, sb, ssum;
      mask = (64'd1 << W) - 1;
      ua = c[6] ? 0 : longint'(a);
      if (c[5]) ua = ~ua & mask;
      ub = c[4] ? 0 : longint'(b);
      if (c[3]) ub = ~ub & mask;
      ecy = 1'b0;
      eov = 1'b0;
      if (c[0]) begin
         r    = ua * ub;
         ecy  = (r >> W) != 0;
         r    = r & mask;
         elat = W + 1;
      end else begin
         if (c[2]) begin
            r    = ua + ub;
            ecy  = (r >> W) != 0;
            sa   = (ua >= (64'd1 << (W-1))) ? longint'(ua) - (longint'(1) << W) : longint'(ua);
            sb   = (ub >= (64'd1 << (W-1))) ? longint'(ub) - (longint'(1) << W) : longint'(ub);
            ssum = sa + sb;
            eov  = (ssum > (longint'(1) << (W-1)) - 1) || (ssum < -(longint'(1) << (W-1)));
            r    = r & mask;
         end else begin
            r = ua & ub;
         end
         if (c[1]) r = ~r & mask;
         elat = 1;
      end
      eo  = W'(r);
      ezr = (r == 0);
      eng = r[W-1];
   endtask

   task automatic scramble();
      x  = W'($urandom);
      y  = W'($urandom);
      {zx, nx, zy, ny, f, no, mul} = 7'($urandom);
   endtask

   // c = {zx,nx,zy,ny,f,no,mul}
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [6:0] c,
                         input int stall);
      logic [W-1:0] eo;
      logic ezr, eng, ecy, eov;
      int elat, lat, k;
      model(a, b, c, eo, ezr, eng, ecy, eov, elat);
      k = 0;
      while (!in_ready && k < 4) begin
         tick();
         k++;
      end
      chk("in_ready_idle", in_ready, 1);
      x = a;
      y = b;
      {zx, nx, zy, ny, f, no, mul} = c;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      scramble();
      lat = 1;
      while (!out_valid && lat < W + 4) begin
         chk("busy_in_ready", in_ready, 0);
         in_valid  = 1'($urandom);
         out_ready = 1'($urandom);
         scramble();
         tick();
         lat++;
      end
      out_ready = 1'b0;
      chk("latency", lat, elat);
      chk("out", out, eo);
      chk("zr", zr, ezr);
      chk("ng", ng, eng);
      chk("cy", cy, ecy);
      chk("ov", ov, eov);
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'($urandom);
         scramble();
         tick();
         chk("hold_valid", out_valid, 1);
         chk("hold_out", out, eo);
         chk("hold_flags", {zr, ng, cy, ov}, {ezr, eng, ecy, eov});
         chk("hold_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("xfer_valid", out_valid, 0);
      chk("xfer_in_ready", in_ready, 1);
   endtask

   initial begin
      int stale;
      reset = 1'b1;
      repeat (2) tick();
      chk("rst_out", out, 0);
      chk("rst_flags", {zr, ng, cy, ov}, 4'b0000);
      chk("rst_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      reset = 1'b0;

      run_op(16'd5, 16'd3, 7'b0000100, 0);
      run_op(16'h7FFF, 16'd1, 7'b0000100, 0);
      run_op(16'hFFFF, 16'd1, 7'b0000100, 0);
      run_op(16'h1234, 16'h5678, 7'b1010110, 0);
      run_op(16'hF0F0, 16'h3C3C, 7'b0000000, 0);
      run_op(16'd300, 16'd300, 7'b0000001, 0);
      run_op(16'hABCD, 16'h0000, 7'b0000100, 5);
      run_op(16'hFFFF, 16'hFFFF, 7'b0000001, 2);

      // Abort a multiply on its 6th MUL cycle
      x = 16'd300; y = 16'd300; {zx, nx, zy, ny, f, no, mul} = 7'b0000001;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_valid", out_valid, 0);
      chk("abort_out", out, 0);
      chk("abort_in_ready", in_ready, 1);
      stale = 0;
      for (int i = 0; i < W + 4; i++) begin
         tick();
         if (out_valid) stale++;
      end
      chk("abort_no_stale", stale, 0);

      for (int i = 0; i < 40; i++) begin
         logic [6:0] c;
         c = 7'($urandom);
         c[0] = ($urandom_range(0, 2) == 0);
         run_op(W'($urandom), W'($urandom), c, $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
